// File: rtl/bus_ctrl.sv
// bus_ctrl: core-side load/store port decoded onto a zero-wait RAM and a
// handshaked IO bus, with IO timeout, unmapped-address detection and a
// sticky error register that remembers the first faulting address.
module bus_ctrl #(
    parameter int RAM_AW     = 10,
    parameter int IO_TIMEOUT = 15
) (
    input  logic              clk_in,
    input  logic              reset_in,
    // core side
    input  logic              rd_in,
    input  logic              wr_in,
    input  logic [3:0]        be_in,
    input  logic [31:0]       addr_in,
    input  logic [31:0]       wdata_in,
    output logic [31:0]       rdata_out,
    output logic              hlt_out,
    // RAM side
    output logic              ram_en_out,
    output logic              ram_we_out,
    output logic [3:0]        ram_be_out,
    output logic [RAM_AW-1:0] ram_addr_out,
    output logic [31:0]       ram_wdata_out,
    input  logic [31:0]       ram_rdata_in,
    // IO side
    output logic              io_req_out,
    output logic              io_we_out,
    output logic [3:0]        io_be_out,
    output logic [7:0]        io_addr_out,
    output logic [31:0]       io_wdata_out,
    input  logic [31:0]       io_rdata_in,
    input  logic              io_ack_in,
    // error reporting
    output logic              err_out,
    output logic [31:0]       err_addr_out,
    input  logic              err_clr_in
);

    localparam int CW = $clog2(IO_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RAM_RD, IO_WAIT, IO_DONE, ERR} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          io_req_q, io_we_q;
    logic [3:0]    io_be_q;
    logic [31:0]   io_addr_q, io_wdata_q, rdata_q;
    logic          err_q;
    logic [31:0]   err_addr_q;

    // Access decode; read wins when both strobes are high.
    logic rd_eff, wr_eff, acc, sel_ram, sel_io, idle;
    logic start_ram, start_io, start_bad, io_tmo, err_set;

    assign rd_eff    = rd_in;
    assign wr_eff    = wr_in & ~rd_in;
    assign acc       = rd_eff | wr_eff;
    assign sel_ram   = addr_in[31];
    assign sel_io    = (addr_in[31:28] == 4'h1);
    assign idle      = (state_q == IDLE);
    assign start_ram = idle & acc & sel_ram;
    assign start_io  = idle & acc & sel_io;
    assign start_bad = idle & acc & ~sel_ram & ~sel_io;
    // Timeout fires on the last allowed wait cycle; a coincident ack wins.
    assign io_tmo    = (state_q == IO_WAIT) & ~io_ack_in & (cnt_q == CW'(IO_TIMEOUT - 1));
    assign err_set   = start_bad | io_tmo;

    // RAM is driven straight from the core request so writes finish in IDLE.
    assign ram_en_out    = start_ram;
    assign ram_we_out    = start_ram & wr_eff;
    assign ram_be_out    = be_in;
    assign ram_addr_out  = addr_in[RAM_AW+1:2];
    assign ram_wdata_out = wdata_in;

    // IO outputs come from registers so they stay stable across the wait.
    assign io_req_out   = io_req_q;
    assign io_we_out    = io_we_q;
    assign io_be_out    = io_be_q;
    assign io_addr_out  = io_addr_q[9:2];
    assign io_wdata_out = io_wdata_q;

    assign err_out      = err_q;
    assign err_addr_out = err_addr_q;

    // Stall every access except a RAM write, plus the whole IO wait.
    assign hlt_out = (idle & acc & ~(sel_ram & wr_eff)) | (state_q == IO_WAIT);

    // Read data is only non-zero in the completion cycle of a read.
    always_comb begin
        rdata_out = '0;
        case (state_q)
            RAM_RD:  rdata_out = ram_rdata_in;
            IO_DONE: rdata_out = rdata_q;
            default: rdata_out = '0;
        endcase
    end

    // Main FSM with the registered IO request and captured read data.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            io_req_q   <= 1'b0;
            io_we_q    <= 1'b0;
            io_be_q    <= '0;
            io_addr_q  <= '0;
            io_wdata_q <= '0;
            rdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ram && rd_eff) begin
                        state_q <= RAM_RD;
                    end else if (start_io) begin
                        state_q    <= IO_WAIT;
                        cnt_q      <= '0;
                        io_req_q   <= 1'b1;
                        io_we_q    <= wr_eff;
                        io_be_q    <= be_in;
                        io_addr_q  <= addr_in;
                        io_wdata_q <= wdata_in;
                    end else if (start_bad) begin
                        state_q <= ERR;
                    end
                end
                IO_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (io_ack_in) begin
                        rdata_q  <= io_rdata_in;
                        io_req_q <= 1'b0;
                        io_we_q  <= 1'b0;
                        state_q  <= IO_DONE;
                    end else if (io_tmo) begin
                        rdata_q  <= '0;
                        io_req_q <= 1'b0;
                        io_we_q  <= 1'b0;
                        state_q  <= IO_DONE;
                    end
                end
                RAM_RD, IO_DONE, ERR: state_q <= IDLE;
                default:              state_q <= IDLE;
            endcase
        end
    end

    // Sticky error: a new error beats a clear; only the first address is kept.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            if (err_set) begin
                err_q <= 1'b1;
                if (!err_q) err_addr_q <= start_bad ? addr_in : io_addr_q;
            end else if (err_clr_in) begin
                err_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_ctrl.sv
// Scoreboard bench for bus_ctrl: a small RAM model and a delay-programmable
// IO responder surround the DUT; expected read data is queued at issue time.
module tb_bus_ctrl;

    logic        clk_in = 1'b0, reset_in = 1'b1;
    logic        rd_in = 0, wr_in = 0, err_clr_in = 0, io_ack_in = 0;
    logic [3:0]  be_in = 0;
    logic [31:0] addr_in = 0, wdata_in = 0, io_rdata_in = 0, ram_rdata_in = 0;
    logic [31:0] rdata_out, io_wdata_out, ram_wdata_out, err_addr_out;
    logic        hlt_out, ram_en_out, ram_we_out, io_req_out, io_we_out, err_out;
    logic [3:0]  ram_be_out, io_be_out;
    logic [9:0]  ram_addr_out;
    logic [7:0]  io_addr_out;

    bus_ctrl #(.RAM_AW(10), .IO_TIMEOUT(15)) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .rd_in(rd_in), .wr_in(wr_in), .be_in(be_in), .addr_in(addr_in),
        .wdata_in(wdata_in), .rdata_out(rdata_out), .hlt_out(hlt_out),
        .ram_en_out(ram_en_out), .ram_we_out(ram_we_out), .ram_be_out(ram_be_out),
        .ram_addr_out(ram_addr_out), .ram_wdata_out(ram_wdata_out),
        .ram_rdata_in(ram_rdata_in),
        .io_req_out(io_req_out), .io_we_out(io_we_out), .io_be_out(io_be_out),
        .io_addr_out(io_addr_out), .io_wdata_out(io_wdata_out),
        .io_rdata_in(io_rdata_in), .io_ack_in(io_ack_in),
        .err_out(err_out), .err_addr_out(err_addr_out), .err_clr_in(err_clr_in)
    );

    always #5 clk_in = ~clk_in;

    int n_chk = 0, n_fail = 0;
    logic [31:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // RAM model: byte-enabled write, read data one cycle after enable.
    logic [31:0] mem [1024];
    initial for (int i = 0; i < 1024; i++) mem[i] = '0;
    always @(posedge clk_in) begin
        if (ram_en_out && ram_we_out) begin
            for (int b = 0; b < 4; b++)
                if (ram_be_out[b]) mem[ram_addr_out][b*8 +: 8] <= ram_wdata_out[b*8 +: 8];
        end else if (ram_en_out) begin
            ram_rdata_in <= mem[ram_addr_out];
        end
    end

    // IO responder: acks in the ack_dly-th cycle of io_req_out (0 = never).
    int ack_dly = 0, req_cnt = 0, req_len = 0;
    initial forever begin
        @(negedge clk_in);
        req_cnt = io_req_out ? req_cnt + 1 : 0;
        if (io_req_out) req_len = req_cnt;
        io_ack_in = (ack_dly != 0) && io_req_out && (req_cnt == ack_dly);
    end

    // RAM enable and IO request must never overlap.
    initial forever begin
        @(negedge clk_in);
        #4;
        if (!reset_in) chk("excl", {31'b0, ram_en_out & io_req_out}, 32'h0);
    end

    logic       s_en, s_we, s_req, s_iowe;
    logic [7:0] s_ioa;

    // One core access: drive, queue expected data, count stall cycles,
    // compare read data in the first non-stalled cycle.
    task automatic acc(input logic rd, input logic wr, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input int exp_hlt);
        int  n;
        bit  done;
        n = 0; done = 0;
        @(negedge clk_in);
        rd_in = rd; wr_in = wr; be_in = be; addr_in = a; wdata_in = wd;
        sb.push_back(exp_rd);
        s_en = 0; s_we = 0; s_req = 0; s_iowe = 0; s_ioa = 0; req_len = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            #4;
            s_en |= ram_en_out; s_we |= ram_we_out; s_req |= io_req_out;
            if (io_req_out) begin s_ioa = io_addr_out; s_iowe |= io_we_out; end
            if (hlt_out) n++;
            else begin done = 1; chk("rdata", rdata_out, sb.pop_front()); end
            @(negedge clk_in);
            rd_in = 0; wr_in = 0; be_in = 0; addr_in = 0; wdata_in = 0;
        end
        chk("hlt_bound", {31'b0, done}, 32'h1);
        chk("hlt_cycles", n, exp_hlt);
    endtask

    task automatic clr_pulse();
        @(negedge clk_in); err_clr_in = 1;
        @(negedge clk_in); err_clr_in = 0;
        #4 chk("err_after_clr", {31'b0, err_out}, 32'h0);
    endtask

    initial begin
        // reset state
        #8;
        chk("rst_hlt", {31'b0, hlt_out}, 0);
        chk("rst_ram_en", {31'b0, ram_en_out}, 0);
        chk("rst_io_req", {31'b0, io_req_out}, 0);
        chk("rst_err", {31'b0, err_out}, 0);
        chk("rst_err_addr", err_addr_out, 0);
        chk("rst_rdata", rdata_out, 0);
        @(negedge clk_in); reset_in = 0;

        // RAM write then read, then a partial-byte overwrite
        acc(0, 1, 4'hF, 32'h8000_0010, 32'hA5A5_A5A5, 32'h0, 0);
        chk("ramwr_en", {31'b0, s_en}, 1);
        chk("ramwr_we", {31'b0, s_we}, 1);
        acc(1, 0, 4'hF, 32'h8000_0010, 32'h0, 32'hA5A5_A5A5, 1);
        chk("ramrd_we", {31'b0, s_we}, 0);
        acc(0, 1, 4'h3, 32'h8000_0010, 32'h1122_3344, 32'h0, 0);
        acc(1, 0, 4'hF, 32'h8000_0010, 32'h0, 32'hA5A5_3344, 1);

        // IO read, ack in the 3rd wait cycle
        ack_dly = 3; io_rdata_in = 32'h1234_5678;
        acc(1, 0, 4'hF, 32'h1000_0008, 32'h0, 32'h1234_5678, 4);
        chk("io_addr", {24'b0, s_ioa}, 32'h02);
        chk("io_rd_we", {31'b0, s_iowe}, 0);
        chk("io_rd_noram", {31'b0, s_en}, 0);

        // IO write, ack in the 1st wait cycle
        ack_dly = 1; io_rdata_in = 32'h0;
        acc(0, 1, 4'hF, 32'h1000_0040, 32'hFEED_0001, 32'h0, 2);
        chk("io_wr_we", {31'b0, s_iowe}, 1);
        chk("io_wr_addr", {24'b0, s_ioa}, 32'h10);

        // ack coincident with timeout counts as success
        ack_dly = 15; io_rdata_in = 32'hCAFE_F00D;
        acc(1, 0, 4'hF, 32'h1000_0004, 32'h0, 32'hCAFE_F00D, 16);
        chk("ack_at_tmo_err", {31'b0, err_out}, 0);

        // IO timeout
        ack_dly = 0; io_rdata_in = 32'hFFFF_FFFF;
        acc(1, 0, 4'hF, 32'h1000_0000, 32'h0, 32'h0, 16);
        chk("tmo_req_len", req_len, 15);
        chk("tmo_err", {31'b0, err_out}, 1);
        chk("tmo_err_addr", err_addr_out, 32'h1000_0000);

        // second error keeps the first address
        acc(1, 0, 4'hF, 32'h3000_0000, 32'h0, 32'h0, 1);
        chk("err2_addr", err_addr_out, 32'h1000_0000);
        clr_pulse();

        // unmapped write: no side effect
        acc(0, 1, 4'hF, 32'h2000_0000, 32'h5555_5555, 32'h0, 1);
        chk("unm_en", {31'b0, s_en}, 0);
        chk("unm_req", {31'b0, s_req}, 0);
        chk("unm_err", {31'b0, err_out}, 1);
        chk("unm_err_addr", err_addr_out, 32'h2000_0000);

        // clear and new error in the same cycle: error wins
        @(negedge clk_in);
        err_clr_in = 1; rd_in = 1; addr_in = 32'h4000_0000;
        @(negedge clk_in);
        err_clr_in = 0; rd_in = 0; addr_in = 0;
        #4 chk("clr_vs_err", {31'b0, err_out}, 1);
        chk("clr_vs_err_addr", err_addr_out, 32'h2000_0000);
        clr_pulse();

        // simultaneous rd/wr is a read
        acc(0, 1, 4'hF, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0, 0);
        acc(1, 1, 4'hF, 32'h8000_0000, 32'h0000_0000, 32'hDEAD_BEEF, 1);
        chk("rdwr_we", {31'b0, s_we}, 0);

        // reset in the 2nd IO wait cycle
        acc(1, 0, 4'hF, 32'h3000_0000, 32'h0, 32'h0, 1);  // leave err set
        ack_dly = 0;
        @(negedge clk_in); rd_in = 1; be_in = 4'hF; addr_in = 32'h1000_0000;
        @(negedge clk_in); rd_in = 0; be_in = 0; addr_in = 0;
        @(negedge clk_in);
        #1 chk("pre_rst_req", {31'b0, io_req_out}, 1);
        reset_in = 1;
        #1;
        chk("rst_async_req", {31'b0, io_req_out}, 0);
        chk("rst_mid_hlt", {31'b0, hlt_out}, 0);
        chk("rst_mid_err", {31'b0, err_out}, 0);
        @(negedge clk_in);
        reset_in = 0; wr_in = 1; be_in = 4'hF; addr_in = 32'h8000_0020; wdata_in = 32'h7;
        #4;
        chk("post_rst_idle_en", {31'b0, ram_en_out}, 1);
        chk("post_rst_hlt", {31'b0, hlt_out}, 0);
        chk("post_rst_err", {31'b0, err_out}, 0);
        @(negedge clk_in); wr_in = 0; be_in = 0; addr_in = 0; wdata_in = 0;
        repeat (2) @(negedge clk_in);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_ctrl.md
BUS_CTRL -- requirements
Module: bus_ctrl

Interface
REQ-001 The block SHALL have parameter RAM_AW, default 10, meaning the RAM word-address width.
REQ-002 The block SHALL have parameter IO_TIMEOUT, default 15, meaning the maximum number of cycles to wait for io_ack_in before aborting.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Clock port: clk_in  in  1  system clock; all state is updated on its rising edge.
REQ-005 Reset port: reset_in  in  1  asynchronous, active-high reset.
REQ-006 Core-side ports:
- rd_in  in  1  read strobe.
- wr_in  in  1  write strobe.
- be_in  in  4  byte enables.
- addr_in  in  32  byte address.
- wdata_in  in  32  write data.
- rdata_out  out  32  read data to core.
- hlt_out  out  1  core stall.
REQ-007 RAM-side ports:
- ram_en_out  out  1.
- ram_we_out  out  1.
- ram_be_out  out  4.
- ram_addr_out  out  RAM_AW  word address (addr_in[RAM_AW+1:2]).
- ram_wdata_out  out  32.
- ram_rdata_in  in  32  valid one cycle after ram_en_out.
REQ-008 IO-side ports:
- io_req_out  out  1.
- io_we_out  out  1.
- io_be_out  out  4.
- io_addr_out  out  8  (addr_in[9:2]).
- io_wdata_out  out  32.
- io_rdata_in  in  32.
- io_ack_in  in  1.
REQ-009 Error ports:
- err_out  out  1  sticky bus error.
- err_addr_out  out  32  address of the first error.
- err_clr_in  in  1  clears err_out.

Function
REQ-010 Decode SHALL be: addr_in[31]=1 selects RAM; addr_in[31:28]=4'h1 selects IO; any other address is unmapped.
REQ-011 A read SHALL be effective when rd_in=1, and a write SHALL be effective when wr_in=1 and rd_in=0; rd_in has priority when both are high.
REQ-012 FSM states SHALL be IDLE, RAM_RD, IO_WAIT, IO_DONE and ERR; the only state that accepts a new access is IDLE.
REQ-013 RAM write in IDLE SHALL complete in zero wait states: ram_en_out=1, ram_we_out=1 and ram_be_out=be_in in the same cycle, with hlt_out=0 and the FSM remaining in IDLE.
REQ-014 RAM read in IDLE SHALL:
- drive ram_en_out=1, ram_we_out=0 and hlt_out=1 combinationally, then move to RAM_RD;
- in RAM_RD, drive hlt_out=0 and rdata_out=ram_rdata_in, then return to IDLE.
REQ-015 IO access in IDLE SHALL:
- assert io_req_out, with io_we_out set for writes, and move to IO_WAIT with hlt_out=1;
- hold io_req_out, io_addr_out, io_be_out and io_wdata_out stable until io_ack_in.
REQ-016 In IO_WAIT, io_ack_in=1 SHALL capture io_rdata_in into a register, deassert io_req_out the next cycle and move to IO_DONE.
REQ-017 IO_DONE SHALL drive hlt_out=0 and rdata_out equal to the captured value, then return to IDLE.
REQ-018 The IO wait counter SHALL clear on entry to IO_WAIT and increment each IO_WAIT cycle.
REQ-019 If the IO wait counter reaches IO_TIMEOUT with io_ack_in=0, the block SHALL:
- drop io_req_out;
- set err_out;
- return 0x00000000 as read data;
- proceed via IO_DONE.
REQ-020 io_ack_in=1 arriving in the same cycle as the timeout SHALL be treated as a successful acknowledge.
REQ-021 An unmapped access SHALL assert hlt_out for one cycle, move to ERR and set err_out; ERR SHALL drive hlt_out=0 and rdata_out=0, then return to IDLE, and unmapped writes SHALL have no side effect.
REQ-022 err_addr_out SHALL latch addr_in only when err_out is 0 at the time of the error.
REQ-023 err_clr_in SHALL clear err_out the next cycle; a new error in the same cycle as err_clr_in SHALL win and leave err_out set.
REQ-024 ram_en_out and io_req_out SHALL never be asserted in the same cycle.
REQ-025 Outside the cycles defined above, rdata_out SHALL be 0.

Reset
REQ-026 While reset_in=1, the FSM SHALL be held in IDLE and the following SHALL all be 0: hlt_out, ram_en_out, ram_we_out, io_req_out, io_we_out, err_out, err_addr_out, the IO wait counter and the captured read data.
REQ-027 Reset asserted during IO_WAIT SHALL drop io_req_out immediately (asynchronously) and SHALL NOT set err_out.

Verification
REQ-028 RAM write then read: wr 0x80000010 with data 0xA5A5A5A5 and be 4'hF, then rd of the same address -> write has hlt_out=0; read has hlt_out=1 for one cycle, then rdata_out=0xA5A5A5A5.
REQ-029 IO read with ack after 3 cycles: rd 0x10000008 with io_rdata_in=0x12345678 -> io_addr_out=8'h02, hlt_out=1 for 4 cycles, then rdata_out=0x12345678 for one cycle.
REQ-030 IO timeout: rd 0x10000000 with io_ack_in never asserted -> io_req_out drops after 15 wait cycles, err_out=1, err_addr_out=0x10000000, rdata_out=0.
REQ-031 Unmapped write to 0x20000000 -> no ram_en_out or io_req_out, err_out=1; a subsequent err_clr_in pulse -> err_out=0.
REQ-032 Simultaneous rd_in and wr_in to 0x80000000 -> treated as a read, ram_we_out stays 0.
REQ-033 Reset pulse in the 2nd IO_WAIT cycle -> io_req_out=0, hlt_out=0, err_out=0, and the FSM is in IDLE on the first cycle after reset release.
